// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder datapath: feeder FSM states,
// default operand geometry and frame-size helpers.
package serial_add_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH  = 8;
   localparam int DEFAULT_EXTEND = 1;

   // Bits per serial frame: operand bits plus trailing zero padding.
   function automatic int nbits_of(input int width, input int extend);
      return width + extend;
   endfunction

   function automatic int count_width(input int nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, LSB first, zero fill on shift.
// Load takes priority over shift.
module piso_shift_reg #(
   parameter int N = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [N-1:0] i_data,
   output logic         o_serial
);

   logic [N-1:0] r_sreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
      end else if (i_shift) begin
         r_sreg <= {1'b0, r_sreg[N-1:1]};
      end
   end

   assign o_serial = r_sreg[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// Serialises a pair of parallel operands LSB first with first/last frame
// markers, feeding the bit-serial adder one bit per clock.
module serial_operand_shifter
   import serial_add_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int EXTEND = DEFAULT_EXTEND
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             first_bit,
   output logic             last_bit,
   output logic             busy
);

   localparam int NBITS = nbits_of(WIDTH, EXTEND);
   localparam int CW    = count_width(NBITS);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_next;
   logic            r_first;
   logic            w_first_next;
   logic            r_last;
   logic            w_last_next;
   logic            w_at_last;
   logic            w_accept;
   logic            w_shift;
   logic [NBITS-1:0] w_load_a;
   logic [NBITS-1:0] w_load_b;
   logic            w_serial_a;
   logic            w_serial_b;

   assign w_at_last = (r_state == SHIFT) && (r_count == LAST_IDX);
   assign in_ready  = !rst && ((r_state == IDLE) || w_at_last);
   assign w_accept  = in_valid && in_ready;
   assign w_shift   = (r_state == SHIFT) && !w_accept;

   // Padding bits above the operand are zero so the adder flushes its carry.
   assign w_load_a = NBITS'(op_a);
   assign w_load_b = NBITS'(op_b);

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_first_next = 1'b0;
      w_last_next  = 1'b0;
      if (w_accept) begin
         w_state_next = SHIFT;
         w_count_next = '0;
         w_first_next = 1'b1;
      end else begin
         case (r_state)
            SHIFT: begin
               if (r_count == LAST_IDX) begin
                  w_state_next = IDLE;
                  w_count_next = '0;
               end else begin
                  w_count_next = r_count + CW'(1);
                  w_last_next  = ((r_count + CW'(1)) == LAST_IDX);
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_first <= w_first_next;
         r_last  <= w_last_next;
      end
   end

   // The shift registers empty themselves over a frame, so a/b read 0 in IDLE
   // without extra gating.
   piso_shift_reg #(.N(NBITS)) u_piso_a (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_shift  (w_shift),
      .i_data   (w_load_a),
      .o_serial (w_serial_a)
   );

   piso_shift_reg #(.N(NBITS)) u_piso_b (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_accept),
      .i_shift  (w_shift),
      .i_data   (w_load_b),
      .o_serial (w_serial_b)
   );

   assign a         = w_serial_a;
   assign b         = w_serial_b;
   assign bit_valid = (r_state == SHIFT);
   assign busy      = (r_state == SHIFT);
   assign first_bit = r_first;
   assign last_bit  = r_last;

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Bench for serial_operand_shifter: a WIDTH=4/EXTEND=1 and a WIDTH=8/EXTEND=0
// instance checked every cycle against a frame-level reference model.
module tb_serial_operand_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv4, iv8;
   logic [3:0] opa4, opb4;
   logic [7:0] opa8, opb8;
   logic [1:0] rdy, ao, bo, bv, fb, lb, bz;

   always #5 clk = ~clk;

   serial_operand_shifter #(.WIDTH(4), .EXTEND(1)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy[0]),
      .op_a(opa4), .op_b(opb4), .a(ao[0]), .b(bo[0]), .bit_valid(bv[0]),
      .first_bit(fb[0]), .last_bit(lb[0]), .busy(bz[0])
   );

   serial_operand_shifter #(.WIDTH(8), .EXTEND(0)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy[1]),
      .op_a(opa8), .op_b(opb8), .a(ao[1]), .b(bo[1]), .bit_valid(bv[1]),
      .first_bit(fb[1]), .last_bit(lb[1]), .busy(bz[1])
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: frame in flight, index of the bit being shown.
   int          m_active[2];
   int          m_idx[2];
   logic [31:0] m_a[2];
   logic [31:0] m_b[2];
   int          nb[2] = '{5, 8};
   int          wd[2] = '{4, 8};
   logic [31:0] cap_a[2];
   logic [31:0] cap_b[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_active[d] = 0;
         m_idx[d]    = 0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_ready%0d", tag, d), {31'b0, rdy[d]}, 32'd0);
         check($sformatf("%s_a%0d", tag, d), {31'b0, ao[d]}, 32'd0);
         check($sformatf("%s_b%0d", tag, d), {31'b0, bo[d]}, 32'd0);
         check($sformatf("%s_valid%0d", tag, d), {31'b0, bv[d]}, 32'd0);
         check($sformatf("%s_marks%0d", tag, d), {30'b0, fb[d], lb[d]}, 32'd0);
      end
   endtask

   // One clock: drive inputs, check all outputs against the model, advance it.
   task automatic cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1);
      logic        vv[2];
      logic [31:0] aa[2];
      logic [31:0] bb[2];
      logic        er, ea, eb, act;
      logic [31:0] mask;
      vv[0] = v0; aa[0] = a0; bb[0] = b0;
      vv[1] = v1; aa[1] = a1; bb[1] = b1;
      iv4 = v0; opa4 = a0[3:0]; opb4 = b0[3:0];
      iv8 = v1; opa8 = a1[7:0]; opb8 = b1[7:0];
      #1;
      for (int d = 0; d < 2; d++) begin
         act = (m_active[d] != 0);
         er  = !act || (m_idx[d] == nb[d] - 1);
         ea  = act ? m_a[d][m_idx[d]] : 1'b0;
         eb  = act ? m_b[d][m_idx[d]] : 1'b0;
         check($sformatf("ready%0d", d), {31'b0, rdy[d]}, {31'b0, er});
         check($sformatf("a%0d", d), {31'b0, ao[d]}, {31'b0, ea});
         check($sformatf("b%0d", d), {31'b0, bo[d]}, {31'b0, eb});
         check($sformatf("valid%0d", d), {31'b0, bv[d]}, {31'b0, act});
         check($sformatf("busy%0d", d), {31'b0, bz[d]}, {31'b0, act});
         check($sformatf("first%0d", d), {31'b0, fb[d]}, {31'b0, act && m_idx[d] == 0});
         check($sformatf("last%0d", d), {31'b0, lb[d]}, {31'b0, act && m_idx[d] == nb[d] - 1});
         if (bv[d]) begin
            cap_a[d] = {ao[d], cap_a[d][31:1]};
            cap_b[d] = {bo[d], cap_b[d][31:1]};
         end
         mask = (32'h1 << wd[d]) - 32'h1;
         if (vv[d] && er) begin
            m_active[d] = 1;
            m_idx[d]    = 0;
            m_a[d]      = aa[d] & mask;
            m_b[d]      = bb[d] & mask;
         end else if (act) begin
            if (m_idx[d] == nb[d] - 1) m_active[d] = 0;
            else m_idx[d]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 0);
   endtask

   initial begin
      logic [4:0] exp5;
      logic [7:0] exp8;
      rst = 1'b1;
      iv4 = 1'b1; opa4 = 4'hB; opb4 = 4'h6;
      iv8 = 1'b1; opa8 = 8'hA5; opb8 = 8'hFF;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         cap_a[d] = '0;
         cap_b[d] = '0;
      end

      // Reset held with in_valid high: no handshake, quiet outputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_all_zero("reset");
      end
      @(negedge clk);
      rst = 1'b0;

      // Single frame 1011/0110 on the 4-bit instance.
      cap_a[0] = '0; cap_b[0] = '0;
      cycle(1'b1, 32'hB, 32'h6, 1'b0, 0, 0);
      idle(6);
      exp5 = 5'b01011;
      check("single_a_seq", {27'b0, cap_a[0][31:27]}, {27'b0, exp5});
      exp5 = 5'b00110;
      check("single_b_seq", {27'b0, cap_b[0][31:27]}, {27'b0, exp5});

      // Back-to-back: second pair held (and first op changed) until last_bit.
      cap_a[0] = '0; cap_b[0] = '0;
      cycle(1'b1, 32'hF, 32'h1, 1'b0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h3, 32'h3, 1'b0, 0, 0);
      idle(6);
      exp5 = 5'b00011;
      check("b2b_a_seq", {27'b0, cap_a[0][31:27]}, {27'b0, exp5});
      check("b2b_b_seq", {27'b0, cap_b[0][31:27]}, {27'b0, exp5});

      // Mid-frame reset during bit 2, then a fresh frame 1/1.
      cycle(1'b1, 32'hB, 32'h6, 1'b0, 0, 0);
      idle(2);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cap_a[0] = '0;
      cycle(1'b1, 32'h1, 32'h1, 1'b0, 0, 0);
      idle(6);
      exp5 = 5'b00001;
      check("post_rst_a_seq", {27'b0, cap_a[0][31:27]}, {27'b0, exp5});

      // EXTEND=0 instance: exactly 8 bits.
      cap_a[1] = '0; cap_b[1] = '0;
      cycle(1'b0, 0, 0, 1'b1, 32'hA5, 32'hFF);
      idle(10);
      exp8 = 8'hA5;
      check("ext0_a_seq", {24'b0, cap_a[1][31:24]}, {24'b0, exp8});
      exp8 = 8'hFF;
      check("ext0_b_seq", {24'b0, cap_b[1][31:24]}, {24'b0, exp8});

      // Randomised traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), $urandom, $urandom,
               ($urandom_range(0, 3) != 0), $urandom, $urandom);
      end
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
